// File: rtl/aud_frame_ctrl_pkg.sv
// Shared audio framing definitions.
// FSM encoding and default frame geometry.
package aud_frame_ctrl_pkg;

  localparam int unsigned C_SAMPLE_W   = 32;
  localparam int unsigned C_FRAME_LOG2 = 7;
  localparam int unsigned C_DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL      = 2'd1,
    ST_WAIT_BANK = 2'd2
  } fill_state_e;

  function automatic logic [1:0] bank_onehot(input logic bank);
    return bank ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/aud_bank_arb.sv
// Ping-pong bank ownership and frame_rdy/ack handshake.
// Reports which banks are free once this cycle's ack is applied.
module aud_bank_arb
  import aud_frame_ctrl_pkg::*;
(
  input  logic       clk_ir,
  input  logic       rst_il,
  input  logic       set_ih,
  input  logic       set_bank_ih,
  input  logic       frame_ack_ih,
  output logic [1:0] bank_full_od,
  output logic [1:0] bank_free_od,
  output logic       frame_rdy_oh,
  output logic       frame_bank_od
);

  logic [1:0] bank_full_q;
  logic [1:0] bank_full_d;
  logic [1:0] ack_mask;
  logic [1:0] set_mask;
  logic       rbank_q;
  logic       rdy_q;
  logic       ack_eff;

  // An ack only counts while a frame is actually presented.
  assign ack_eff  = frame_ack_ih & rdy_q;
  assign ack_mask = ack_eff ? bank_onehot(rbank_q) : 2'b00;
  assign set_mask = set_ih ? bank_onehot(set_bank_ih) : 2'b00;

  // Ack is applied before the fill side looks at occupancy.
  assign bank_full_d  = (bank_full_q & ~ack_mask) | set_mask;
  assign bank_free_od = ~(bank_full_q & ~ack_mask);
  assign bank_full_od = bank_full_q;

  assign frame_rdy_oh  = rdy_q;
  assign frame_bank_od = rbank_q;

  // Occupancy, read pointer and registered ready with a forced gap after ack.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      bank_full_q <= 2'b00;
      rbank_q     <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      if (ack_eff) begin
        rbank_q <= ~rbank_q;
        rdy_q   <= 1'b0;
      end else begin
        rdy_q   <= bank_full_q[rbank_q];
      end
    end
  end

endmodule

// File: rtl/aud_frame_ctrl.sv
// Audio frame writer: fills a ping-pong frame RAM from
// synchronized sample strobes and tracks overruns.
module aud_frame_ctrl
  import aud_frame_ctrl_pkg::*;
#(
  parameter int unsigned P_SAMPLE_W   = C_SAMPLE_W,
  parameter int unsigned P_FRAME_LOG2 = C_FRAME_LOG2,
  parameter int unsigned P_DROP_CNT_W = C_DROP_CNT_W
) (
  input  logic                    clk_ir,
  input  logic                    rst_il,
  input  logic                    enable_ih,
  input  logic                    sample_valid_ih,
  input  logic [P_SAMPLE_W-1:0]   sample_data_id,
  input  logic                    frame_ack_ih,
  input  logic                    clr_ovr_ih,
  output logic                    wr_en_oh,
  output logic [P_FRAME_LOG2:0]   wr_addr_od,
  output logic [P_SAMPLE_W-1:0]   wr_data_od,
  output logic                    frame_rdy_oh,
  output logic                    frame_bank_od,
  output logic                    overrun_oh,
  output logic [P_DROP_CNT_W-1:0] drop_cnt_od
);

  fill_state_e             state_q;
  fill_state_e             state_d;
  logic                    wbank_q;
  logic                    wbank_d;
  logic [P_FRAME_LOG2-1:0] cnt_q;
  logic [P_FRAME_LOG2-1:0] cnt_d;
  logic                    wr_d;
  logic                    set_full;
  logic                    drop;
  logic [1:0]              bank_full;
  logic [1:0]              bank_free;

  logic                    wr_en_q;
  logic [P_FRAME_LOG2:0]   wr_addr_q;
  logic [P_SAMPLE_W-1:0]   wr_data_q;
  logic                    overrun_q;
  logic [P_DROP_CNT_W-1:0] drop_cnt_q;

  aud_bank_arb u_bank_arb (
    .clk_ir        (clk_ir),
    .rst_il        (rst_il),
    .set_ih        (set_full),
    .set_bank_ih   (wbank_q),
    .frame_ack_ih  (frame_ack_ih),
    .bank_full_od  (bank_full),
    .bank_free_od  (bank_free),
    .frame_rdy_oh  (frame_rdy_oh),
    .frame_bank_od (frame_bank_od)
  );

  // Fill FSM: next state, write request, bank completion and drops.
  always_comb begin
    state_d  = state_q;
    wbank_d  = wbank_q;
    cnt_d    = cnt_q;
    wr_d     = 1'b0;
    set_full = 1'b0;
    drop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable_ih) begin
          state_d = bank_full[wbank_q] ? ST_WAIT_BANK : ST_FILL;
        end
      end
      ST_FILL: begin
        if (!enable_ih) begin
          wr_d    = sample_valid_ih;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (sample_valid_ih) begin
          wr_d = 1'b1;
          if (&cnt_q) begin
            set_full = 1'b1;
            cnt_d    = '0;
            if (bank_free[~wbank_q]) begin
              wbank_d = ~wbank_q;
            end else begin
              state_d = ST_WAIT_BANK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_BANK: begin
        drop  = sample_valid_ih;
        cnt_d = '0;
        if (!enable_ih) begin
          state_d = ST_IDLE;
        end else if (bank_free[~wbank_q]) begin
          wbank_d = ~wbank_q;
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, write bank and sample index.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q <= ST_IDLE;
      wbank_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wbank_q <= wbank_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered RAM write port, one cycle behind the strobe.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_d;
      if (wr_d) begin
        wr_addr_q <= {wbank_q, cnt_q};
        wr_data_q <= sample_data_id;
      end
    end
  end

  // Sticky overrun and saturating drop count; clear beats a same-cycle drop.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr_ovr_ih) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overrun_q <= 1'b1;
      if (!(&drop_cnt_q)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign wr_en_oh    = wr_en_q;
  assign wr_addr_od  = wr_addr_q;
  assign wr_data_od  = wr_data_q;
  assign overrun_oh  = overrun_q;
  assign drop_cnt_od = drop_cnt_q;

endmodule

// File: doc/aud_frame_ctrl.md
Name: aud_frame_ctrl

Overview:
- Downstream of the clock-crossing pulse synchronizer in the audio cortex. Runs entirely in the consumer (DSP/FFT) clock domain.
- Takes the synchronized sample-valid strobe and the held sample word, and writes samples into a two-bank (ping-pong) frame RAM.
- Signals frame-ready to the FFT stage and waits for its acknowledge.
- Detects, counts and flags overruns when both banks are occupied.

Parameters:
- P_SAMPLE_W, 32, sample word width (L/R 16b each).
- P_FRAME_LOG2, 7, log2 of samples per frame (128).
- P_DROP_CNT_W, 16, width of the saturating dropped-sample counter.

Ports:
- clk_ir  in  1  block clock
- rst_il  in  1  asynchronous active-low reset
- enable_ih  in  1  capture enable (level)
- sample_valid_ih  in  1  single-cycle sample strobe from synchronizer
- sample_data_id  in  P_SAMPLE_W  held sample, stable when strobe high
- frame_ack_ih  in  1  consumer done with presented bank (1-cycle pulse)
- clr_ovr_ih  in  1  clears overrun flag and drop counter
- wr_en_oh  out  1  frame RAM write enable
- wr_addr_od  out  P_FRAME_LOG2+1  {bank, index}
- wr_data_od  out  P_SAMPLE_W  frame RAM write data
- frame_rdy_oh  out  1  presented bank full, awaiting ack
- frame_bank_od  out  1  bank presented to consumer
- overrun_oh  out  1  sticky, a sample was dropped
- drop_cnt_od  out  P_DROP_CNT_W  saturating dropped-sample count

Behaviour:
- Reset: every output is 0. wbank=0, rbank=0, cnt=0, bank_full=2'b00, state IDLE.
- Write latency: a strobe on cycle N gives wr_en_oh=1 on N+1, with addr={wbank,cnt} and data equal to the sample on N. Strobes may arrive every cycle.
- FSM states:
  - IDLE: enable_ih=1 moves to FILL, or to WAIT_BANK if bank_full[wbank].
  - FILL: each strobe writes and increments cnt. On the strobe where cnt=2^P_FRAME_LOG2-1:
    - set bank_full[wbank] and wrap cnt to 0;
    - if bank_full[~wbank]=0 after this cycle's ack is applied, toggle wbank and stay in FILL;
    - otherwise go to WAIT_BANK and leave wbank unchanged.
  - WAIT_BANK: every strobe is dropped (no write), sets overrun_oh, and increments drop_cnt_od, saturating at all-ones. When bank_full[~wbank] clears, toggle wbank, cnt=0, go to FILL. A strobe arriving in that same cycle is dropped.
- Read side:
  - frame_rdy_oh is registered and equals bank_full[rbank]; frame_bank_od=rbank.
  - An ack while frame_rdy_oh=1 clears bank_full[rbank] and toggles rbank.
  - frame_rdy_oh then drops for at least one cycle before the next frame is presented.
  - An ack while frame_rdy_oh=0 is ignored.
- Simultaneous ack and frame completion: the ack is applied first. The freed bank is immediately usable, so no sample is dropped.
- enable_ih deasserted: go to IDLE on the next cycle.
  - The partial frame is discarded: cnt=0, no bank_full set, wbank unchanged.
  - Full banks stay presented until acked.
  - A strobe in the deassert cycle is still written; later strobes are ignored.
- clr_ovr_ih zeroes overrun_oh and drop_cnt_od. If a drop happens in the same cycle, the clear wins and that drop is not counted.
- Asynchronous reset mid-frame returns everything to the reset values and outputs 0 immediately.

Decomposition:
- Shared audio package holds:
  - FSM state encoding: IDLE=2'd0, FILL=2'd1, WAIT_BANK=2'd2;
  - default frame length and sample width constants.
- One sub-module is natural: aud_bank_arb. It owns bank_full, rbank, and the frame_rdy/ack handshake, and exposes a bank-free query to the fill FSM.

Test Plan (bench uses P_FRAME_LOG2=2, i.e. 4 samples/frame):
- Enable, then 4 strobes with data 0x11..0x44 → writes at addr 0..3 with matching data; frame_rdy_oh=1 with bank 0 one cycle after the last write.
- Ack frame 0, then 4 more strobes → writes at addr 4..7; frame_rdy_oh rises with bank 1; no overrun.
- 8 strobes with no ack, then 3 more → first 8 written; the 3 extra are not written; overrun_oh=1; drop_cnt_od=3.
- Ack bank 0 on the same cycle as the strobe completing bank 1 → wbank returns to 0; the next strobe writes addr 0; drop_cnt_od stays 0.
- Drop enable after 2 samples, then re-enable and send 4 strobes → writes at addr 0..3 again; frame_rdy_oh only after the 4th.
- Assert rst_il low mid-frame → all outputs 0 immediately; after release, the first strobe writes addr 0.
